// File: rtl/ahb_rr_arbiter.sv
// Round-robin AHB bus arbiter. Shares one subordinate segment among NUM_MGRS managers,
// hands the address-phase grant over only at transfer boundaries, honours locked
// sequences, and limits how many transfers an owner may issue while others wait.
// Also tracks which manager owns the data phase so response steering stays correct.
module ahb_rr_arbiter #(
    parameter int unsigned NUM_MGRS    = 4,
    parameter int unsigned DEFAULT_MGR = 0,
    parameter int unsigned MAX_HOLD    = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_MGRS-1:0]         req,
    input  logic [NUM_MGRS-1:0]         lock,
    input  logic [1:0]                  trans,
    input  logic                        readyIn,
    output logic [NUM_MGRS-1:0]         grant,
    output logic [$clog2(NUM_MGRS)-1:0] ownerId,
    output logic [$clog2(NUM_MGRS)-1:0] dataOwnerId,
    output logic                        ownerLocked
);

    localparam int unsigned IdW   = $clog2(NUM_MGRS);
    localparam int unsigned HoldW = $clog2(MAX_HOLD + 1);

    localparam logic [1:0] TransIdle   = 2'd0;
    localparam logic [1:0] TransNonseq = 2'd2;
    localparam logic [1:0] TransSeq    = 2'd3;

    typedef enum logic [1:0] {
        StPark   = 2'd0,
        StOwned  = 2'd1,
        StLocked = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [NUM_MGRS-1:0]   grant_q, grant_d;
    logic [IdW-1:0]        owner_q, owner_d;
    logic [IdW-1:0]        data_owner_q, data_owner_d;
    logic                  owner_locked_q, owner_locked_d;
    logic [HoldW-1:0]      hold_cnt_q, hold_cnt_d;
    logic [IdW-1:0]        rr_ptr_q, rr_ptr_d;

    logic                  boundary;
    logic                  xfer_done;
    logic                  hold_expired;
    logic                  hold_clr;
    logic [NUM_MGRS-1:0]   owner_oh;
    logic [NUM_MGRS-1:0]   others_req;
    logic                  other_req;
    logic [NUM_MGRS-1:0]   cand;
    logic                  cand_any;
    logic [IdW-1:0]        winner;

    // Decode the current owner and which competing requests are visible to the picker.
    always_comb begin
        owner_oh          = '0;
        owner_oh[owner_q] = 1'b1;
        others_req        = req & ~owner_oh;
        other_req         = |others_req;
        // While parked every request competes, including the default manager's.
        cand              = (state_q == StPark) ? req : others_req;
        boundary          = readyIn && ((trans == TransIdle) || (trans == TransNonseq))
                            && !owner_locked_q;
        xfer_done         = readyIn && ((trans == TransNonseq) || (trans == TransSeq));
        hold_expired      = (hold_cnt_q >= HoldW'(MAX_HOLD));
    end

    // Round-robin pick: first candidate found scanning upward from the slot after rr_ptr.
    always_comb begin
        int unsigned idx;
        idx      = 0;
        cand_any = 1'b0;
        winner   = rr_ptr_q;
        for (int unsigned off = 1; off <= NUM_MGRS; off++) begin
            idx = (int'(rr_ptr_q) + off) % NUM_MGRS;
            if (!cand_any && cand[idx]) begin
                cand_any = 1'b1;
                winner   = idx[IdW-1:0];
            end
        end
    end

    // Ownership FSM: park / owned / locked, plus round-robin pointer and hold-count clears.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        hold_clr = 1'b0;

        unique case (state_q)
            StPark: begin
                if (boundary && cand_any) begin
                    state_d  = StOwned;
                    owner_d  = winner;
                    rr_ptr_d = winner;
                    hold_clr = 1'b1;
                end
            end

            StOwned: begin
                // Lock takes priority so a locked burst is never preempted by MAX_HOLD.
                if (lock[owner_q] && req[owner_q]) begin
                    state_d = StLocked;
                end else if (boundary && (!req[owner_q] || (hold_expired && other_req))) begin
                    hold_clr = 1'b1;
                    if (other_req) begin
                        owner_d  = winner;
                        rr_ptr_d = winner;
                    end else begin
                        state_d = StPark;
                        owner_d = IdW'(DEFAULT_MGR);
                    end
                end else if (boundary && hold_expired) begin
                    // Only the owner wants the bus: it keeps it and starts a fresh quota.
                    hold_clr = 1'b1;
                end
            end

            StLocked: begin
                if (!lock[owner_q] && readyIn && (trans == TransIdle)) begin
                    state_d  = StOwned;
                    hold_clr = 1'b1;
                end
            end

            default: begin
                state_d = StPark;
                owner_d = IdW'(DEFAULT_MGR);
            end
        endcase
    end

    // Registered outputs derived from next-state, hold counter and data-phase tracking.
    always_comb begin
        grant_d          = '0;
        grant_d[owner_d] = 1'b1;
        owner_locked_d   = (state_d == StLocked);
        data_owner_d     = readyIn ? owner_q : data_owner_q;

        hold_cnt_d = hold_cnt_q;
        if (hold_clr) begin
            hold_cnt_d = '0;
        end else if (xfer_done && !hold_expired) begin
            hold_cnt_d = hold_cnt_q + 1'b1;
        end
    end

    // State register with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= StPark;
            grant_q        <= NUM_MGRS'(1) << DEFAULT_MGR;
            owner_q        <= IdW'(DEFAULT_MGR);
            data_owner_q   <= IdW'(DEFAULT_MGR);
            owner_locked_q <= 1'b0;
            hold_cnt_q     <= '0;
            rr_ptr_q       <= IdW'(DEFAULT_MGR);
        end else begin
            state_q        <= state_d;
            grant_q        <= grant_d;
            owner_q        <= owner_d;
            data_owner_q   <= data_owner_d;
            owner_locked_q <= owner_locked_d;
            hold_cnt_q     <= hold_cnt_d;
            rr_ptr_q       <= rr_ptr_d;
        end
    end

    assign grant       = grant_q;
    assign ownerId     = owner_q;
    assign dataOwnerId = data_owner_q;
    assign ownerLocked = owner_locked_q;

endmodule

// File: tb/tb_ahb_rr_arbiter.sv
// Directed bench for ahb_rr_arbiter: a driver issues one cycle of inputs per step and
// queues the hand-computed outputs for the following edge; a monitor compares them.
module tb_ahb_rr_arbiter;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] BUSY   = 2'd1;
    localparam logic [1:0] NONSEQ = 2'd2;
    localparam logic [1:0] SEQ    = 2'd3;

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic [3:0] lock;
    logic [1:0] trans;
    logic       readyIn;
    logic [3:0] grant;
    logic [1:0] ownerId;
    logic [1:0] dataOwnerId;
    logic       ownerLocked;

    typedef struct packed {
        logic [3:0] g;
        logic [1:0] o;
        logic [1:0] d;
        logic       l;
    } exp_t;

    exp_t exp_q[$];
    int   checks;
    int   errors;
    int   cyc;

    ahb_rr_arbiter #(
        .NUM_MGRS   (4),
        .DEFAULT_MGR(0),
        .MAX_HOLD   (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .lock       (lock),
        .trans      (trans),
        .readyIn    (readyIn),
        .grant      (grant),
        .ownerId    (ownerId),
        .dataOwnerId(dataOwnerId),
        .ownerLocked(ownerLocked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: after each rising edge, pop the expected outputs for that edge and compare.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            cyc++;
            checks++;
            if (grant !== e.g || ownerId !== e.o || dataOwnerId !== e.d ||
                ownerLocked !== e.l || !$onehot(grant)) begin
                errors++;
                $display("FAIL step%0d: got grant=%b owner=%0d downer=%0d locked=%b, want grant=%b owner=%0d downer=%0d locked=%b",
                         cyc, grant, ownerId, dataOwnerId, ownerLocked, e.g, e.o, e.d, e.l);
            end
        end
    end

    // Drive one cycle of inputs and queue the outputs expected after the next edge.
    task automatic step(input logic rst, input logic [3:0] rq, input logic [3:0] lk,
                        input logic [1:0] tr, input logic rdy, input logic [3:0] eg,
                        input logic [1:0] eo, input logic [1:0] ed, input logic el);
        exp_t e;
        @(negedge clk);
        reset   = rst;
        req     = rq;
        lock    = lk;
        trans   = tr;
        readyIn = rdy;
        e.g = eg;
        e.o = eo;
        e.d = ed;
        e.l = el;
        exp_q.push_back(e);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        cyc     = 0;
        reset   = 1'b1;
        req     = '0;
        lock    = '0;
        trans   = IDLE;
        readyIn = 1'b1;

        // Reset
        step(1, 4'b0000, 4'b0000, IDLE, 1, 4'b0001, 0, 0, 0);
        step(1, 4'b0000, 4'b0000, IDLE, 1, 4'b0001, 0, 0, 0);

        // Round-robin from park, then release to the next requester
        step(0, 4'b1010, 4'b0000, IDLE, 1, 4'b0010, 1, 0, 0);
        step(0, 4'b1000, 4'b0000, IDLE, 1, 4'b1000, 3, 1, 0);
        step(0, 4'b1000, 4'b0000, IDLE, 1, 4'b1000, 3, 3, 0);
        step(0, 4'b0010, 4'b0000, IDLE, 1, 4'b0010, 1, 3, 0);

        // Stall: owner 1 releases its request but readyIn=0 / SEQ / BUSY block handover
        step(0, 4'b0010, 4'b0000, NONSEQ, 1, 4'b0010, 1, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 4'b0100, 4'b0000, NONSEQ, 0, 4'b0010, 1, 1, 0);
        step(0, 4'b0100, 4'b0000, SEQ,  1, 4'b0010, 1, 1, 0);
        step(0, 4'b0100, 4'b0000, BUSY, 1, 4'b0010, 1, 1, 0);
        step(0, 4'b0100, 4'b0000, IDLE, 1, 4'b0100, 2, 1, 0);

        // Fairness: owner 2 streams with 3 waiting; 8 transfers then forced handover
        for (int i = 0; i < 8; i++) step(0, 4'b1100, 4'b0000, NONSEQ, 1, 4'b0100, 2, 2, 0);
        step(0, 4'b1100, 4'b0000, NONSEQ, 1, 4'b1000, 3, 2, 0);
        step(0, 4'b1000, 4'b0000, NONSEQ, 1, 4'b1000, 3, 3, 0);
        // Sole requester reaches the quota: keeps the bus and the counter restarts
        for (int i = 0; i < 8; i++) step(0, 4'b1000, 4'b0000, NONSEQ, 1, 4'b1000, 3, 3, 0);
        step(0, 4'b1001, 4'b0000, NONSEQ, 1, 4'b1000, 3, 3, 0);

        // Lock raised together with the handover to 2 only takes effect once 2 owns
        step(0, 4'b0100, 4'b0100, IDLE,   1, 4'b0100, 2, 3, 0);
        step(0, 4'b1111, 4'b0100, NONSEQ, 1, 4'b0100, 2, 2, 1);
        for (int i = 0; i < 20; i++) begin
            logic [1:0] tr;
            tr = (i % 5 == 4) ? IDLE : ((i % 2 == 1) ? SEQ : NONSEQ);
            step(0, 4'b1111, 4'b0100, tr, (i % 4 != 3), 4'b0100, 2, 2, 1);
        end
        step(0, 4'b1011, 4'b0000, IDLE, 1, 4'b0100, 2, 2, 0);
        step(0, 4'b1011, 4'b0000, IDLE, 1, 4'b1000, 3, 2, 0);

        // Reset in the middle of owner 3's burst
        step(0, 4'b1000, 4'b0000, NONSEQ, 1, 4'b1000, 3, 3, 0);
        step(0, 4'b1000, 4'b0000, SEQ,    1, 4'b1000, 3, 3, 0);
        step(1, 4'b1000, 4'b0000, SEQ,    1, 4'b0001, 0, 0, 0);
        step(0, 4'b1000, 4'b0000, SEQ,    1, 4'b0001, 0, 0, 0);
        step(0, 4'b1000, 4'b0000, IDLE,   1, 4'b1000, 3, 0, 0);

        // No requests left: park on the default manager
        step(0, 4'b0000, 4'b0000, IDLE, 1, 4'b0001, 0, 3, 0);
        step(0, 4'b0000, 4'b0000, IDLE, 1, 4'b0001, 0, 0, 0);

        // Let the monitor drain; anything left over is a missed comparison
        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d entries left, want 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
